// File: rtl/btb_assoc_predictor.sv
// ---------------------------------------------------------------------------
// btb_assoc_predictor
//
// N-way set-associative branch target buffer. Each entry holds a valid bit,
// an unconditional-jump flag, a 2-bit saturating direction counter, a tag and
// a full 32-bit target. Every set has its own round-robin victim pointer.
//
// Lookup happens in the IF stage and is purely combinational. Training comes
// from the EX stage and is applied on the rising clock edge. A flush request
// starts a walk that clears one set per cycle. The buffer is unusable while
// that walk runs.
//
// Ports
//   clk            clock, all state changes on posedge
//   rst            synchronous active-high reset
//   lookup_pc      IF-stage PC[31:2]
//   hit            a valid way in the indexed set matches the tag
//   is_jump        the hit entry is an unconditional jump
//   predict_taken  hit & (is_jump | ctr[1])
//   target         target of the hit entry, zero on a miss
//   upd_valid      EX stage resolved a control-flow instruction
//   upd_pc         EX-stage PC[31:2]
//   upd_is_jump    1 for jal/jalr, 0 for a conditional branch
//   upd_taken      resolved direction (jumps always count as taken)
//   upd_target     resolved target address
//   flush_req      pulse that invalidates the whole buffer
//   busy           flush walk in progress
// ---------------------------------------------------------------------------
module btb_assoc_predictor #(
  parameter int SETS     = 256,
  parameter int WAYS     = 2,
  parameter int CTR_INIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] lookup_pc,
  output logic        hit,
  output logic        is_jump,
  output logic        predict_taken,
  output logic [31:0] target,
  input  logic        upd_valid,
  input  logic [29:0] upd_pc,
  input  logic        upd_is_jump,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        flush_req,
  output logic        busy
);

  localparam int INDEX = $clog2(SETS);
  localparam int TAG   = 30 - INDEX;
  // The pointer keeps at least one bit so that WAYS == 1 still gives a legal
  // declaration. In that case the pointer is never advanced.
  localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {
    IDLE,
    FLUSH
  } state_t;

  // Entry storage. Only valid bits and pointers need reset or flush clearing.
  // The payload fields are meaningless while their valid bit is low.
  logic [WAYS-1:0]  valid_q  [SETS];
  logic [WAYS-1:0]  jump_q   [SETS];
  logic [1:0]       ctr_q    [SETS][WAYS];
  logic [TAG-1:0]   tag_q    [SETS][WAYS];
  logic [31:0]      target_q [SETS][WAYS];
  logic [PTR_W-1:0] rr_q     [SETS];

  state_t           state_q;
  logic [INDEX-1:0] cnt_q;
  logic             busy_q;

  logic [INDEX-1:0] lk_set;
  logic [TAG-1:0]   lk_tag;
  logic [INDEX-1:0] up_set;
  logic [TAG-1:0]   up_tag;

  logic             up_hit;
  logic [PTR_W-1:0] up_hit_way;
  logic             have_free;
  logic [PTR_W-1:0] free_way;
  logic [PTR_W-1:0] victim_way;
  logic             eff_taken;
  logic             do_update;
  logic             do_alloc;

  assign lk_set = lookup_pc[INDEX-1:0];
  assign lk_tag = lookup_pc[29:INDEX];
  assign up_set = upd_pc[INDEX-1:0];
  assign up_tag = upd_pc[29:INDEX];

  assign busy = busy_q;

  // Lookup compares every way of the indexed set in parallel. Allocation only
  // happens on a miss, so at most one way can match and the first match wins
  // without any priority cost. All outputs are held low during a flush so
  // that half-cleared sets are never seen.
  always_comb begin
    hit           = 1'b0;
    is_jump       = 1'b0;
    predict_taken = 1'b0;
    target        = 32'd0;
    if (!busy_q) begin
      for (int w = 0; w < WAYS; w++) begin
        if (!hit && valid_q[lk_set][w] && (tag_q[lk_set][w] == lk_tag)) begin
          hit           = 1'b1;
          is_jump       = jump_q[lk_set][w];
          predict_taken = jump_q[lk_set][w] | ctr_q[lk_set][w][1];
          target        = target_q[lk_set][w];
        end
      end
    end
  end

  // Update-side decode. The update looks at pre-edge contents, so a lookup of
  // the same PC in the same cycle sees the old entry. The victim is the
  // lowest-numbered free way if the set has one. Otherwise it is the way the
  // round-robin pointer names. The scan runs downward so that the last write
  // leaves the lowest free index.
  always_comb begin
    up_hit     = 1'b0;
    up_hit_way = '0;
    have_free  = 1'b0;
    free_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!up_hit && valid_q[up_set][w] && (tag_q[up_set][w] == up_tag)) begin
        up_hit     = 1'b1;
        up_hit_way = PTR_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[up_set][w]) begin
        have_free = 1'b1;
        free_way  = PTR_W'(w);
      end
    end
    victim_way = have_free ? free_way : rr_q[up_set];
    eff_taken  = upd_is_jump | upd_taken;
    // A simultaneous flush request takes priority, and updates are ignored
    // while a flush walk runs.
    do_update  = upd_valid && !rst && (state_q == IDLE) && !flush_req;
    do_alloc   = do_update && !up_hit && eff_taken;
  end

  // Payload training. A hit on a jump pins the counter at strongly taken. A
  // taken branch counts up and refreshes the target. A not-taken branch only
  // counts down. A not-taken miss is not allocated, so it never consumes a
  // way. New entries start at strongly taken for jumps and at CTR_INIT for
  // branches.
  always_ff @(posedge clk) begin
    if (do_update && up_hit) begin
      if (upd_is_jump) begin
        jump_q[up_set][up_hit_way]   <= 1'b1;
        ctr_q[up_set][up_hit_way]    <= 2'd3;
        target_q[up_set][up_hit_way] <= upd_target;
      end else if (upd_taken) begin
        jump_q[up_set][up_hit_way]   <= 1'b0;
        target_q[up_set][up_hit_way] <= upd_target;
        if (ctr_q[up_set][up_hit_way] != 2'd3) begin
          ctr_q[up_set][up_hit_way] <= ctr_q[up_set][up_hit_way] + 2'd1;
        end
      end else begin
        if (ctr_q[up_set][up_hit_way] != 2'd0) begin
          ctr_q[up_set][up_hit_way] <= ctr_q[up_set][up_hit_way] - 2'd1;
        end
      end
    end else if (do_alloc) begin
      jump_q[up_set][victim_way]   <= upd_is_jump;
      ctr_q[up_set][victim_way]    <= upd_is_jump ? 2'd3 : 2'(CTR_INIT);
      tag_q[up_set][victim_way]    <= up_tag;
      target_q[up_set][victim_way] <= upd_target;
    end
  end

  // Control state. The flush machine and the valid/pointer arrays live
  // together here because both reset and flush clear them. Reset clears
  // every set in one cycle, even in the middle of a flush. A flush walk
  // clears set cnt_q on each cycle and takes exactly SETS cycles. Busy drops
  // on the edge that clears the last set. A pointer advances only when it
  // chose the victim, so free ways are filled before anything is evicted.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush_req) begin
            state_q <= FLUSH;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else if (do_alloc) begin
            valid_q[up_set][victim_way] <= 1'b1;
            if (!have_free && (WAYS > 1)) begin
              rr_q[up_set] <= rr_q[up_set] + PTR_W'(1);
            end
          end
        end
        FLUSH: begin
          valid_q[cnt_q] <= '0;
          rr_q[cnt_q]    <= '0;
          if (cnt_q == INDEX'(SETS - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + INDEX'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
